// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// The line, busy and done outputs are all registered from the next-state logic.
module uart_tx_serializer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic PAR_EN    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic             stop_cnt_r, stop_cnt_s;
  logic [7:0]       shift_r, shift_s;
  logic             parity_r, parity_s;
  logic             tx_s, busy_s, done_s;
  logic             bit_end_s;

  assign bit_end_s = (cnt_r == CNT_LAST);

  // Next-state, datapath and next-output logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    stop_cnt_s = stop_cnt_r;
    shift_s    = shift_r;
    parity_s   = parity_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;
    busy_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tx_start) begin
          shift_s  = tx_data;
          parity_s = calc_parity(tx_data, PAR_ODD);
          cnt_s    = '0;
          state_s  = ST_START;
        end else begin
          cnt_s = '0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_s     = '0;
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s  = 3'd0;
            stop_cnt_s = 1'b0;
            if (PAR_EN) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_s      = '0;
          stop_cnt_s = 1'b0;
          state_s    = ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s = '0;
          if (stop_cnt_r == STOP_LAST) begin
            stop_cnt_s = 1'b0;
            state_s    = ST_IDLE;
            done_s     = 1'b1;
          end else begin
            stop_cnt_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase

    // Outputs follow the state being entered so the pin is registered glitch-free
    case (state_s)
      ST_IDLE:   begin tx_s = 1'b1;       busy_s = 1'b0; end
      ST_START:  begin tx_s = 1'b0;       busy_s = 1'b1; end
      ST_DATA:   begin tx_s = shift_s[0]; busy_s = 1'b1; end
      ST_PARITY: begin tx_s = parity_s;   busy_s = 1'b1; end
      ST_STOP:   begin tx_s = 1'b1;       busy_s = 1'b1; end
      default:   begin tx_s = 1'b1;       busy_s = 1'b0; end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      stop_cnt_r <= stop_cnt_s;
      shift_r    <= shift_s;
      parity_r   <= parity_s;
      tx         <= tx_s;
      tx_busy    <= busy_s;
      tx_done    <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four parameterisations at 16 clocks/bit,
// a frame vector table plus hand-written ignored-request, back-to-back and reset sequences.
module tb_uart_tx_serializer;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] data_a [4];
  wire  [3:0] tx_v, busy_v, done_v;

  int n_checks;
  int n_err;

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [11:0] frame;  // bit j is the j-th bit on the line, start bit first
    int          nbits;
  } vec_t;

  vec_t vecs [9];

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1)) u_basic (
    .clk(clk), .rst_n(rst_n), .tx_start(start_v[0]), .tx_data(data_a[0]),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk(clk), .rst_n(rst_n), .tx_start(start_v[1]), .tx_data(data_a[1]),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk(clk), .rst_n(rst_n), .tx_start(start_v[2]), .tx_data(data_a[2]),
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tx_start(start_v[3]), .tx_data(data_a[3]),
    .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sends one byte and checks the whole frame cycle by cycle; inj_k > 0 pulses a
  // second request carrying inj_d in cycle inj_k of the frame.
  task automatic run_frame(input int inst, input logic [7:0] d, input logic [11:0] frame,
                           input int nbits, input int inj_k, input logic [7:0] inj_d,
                           input string name);
    int n, mism, busy_cnt, done_cnt, ov, busy_first, done_end, tx_end;
    n = CPB * nbits;
    mism = 0; busy_cnt = 0; done_cnt = 0; ov = 0; busy_first = 0; done_end = 0; tx_end = 0;
    @(negedge clk);
    data_a[inst]  = d;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= n) begin
        if (tx_v[inst] !== frame[(k-1)/CPB]) mism++;
      end else begin
        done_end = int'(done_v[inst]);
        tx_end   = int'(tx_v[inst]);
      end
      if (k == 1) busy_first = int'(busy_v[inst]);
      if (busy_v[inst] === 1'b1) busy_cnt++;
      if (done_v[inst] === 1'b1) done_cnt++;
      if (busy_v[inst] === 1'b1 && done_v[inst] === 1'b1) ov++;
      if (inj_k > 0 && k == inj_k + 1) start_v[inst] = 1'b0;
      if (inj_k > 0 && k == inj_k) begin
        data_a[inst]  = inj_d;
        start_v[inst] = 1'b1;
      end
    end
    check({name, " tx_frame_mismatches"}, mism, 0);
    check({name, " busy_first_cycle"}, busy_first, 1);
    check({name, " busy_len"}, busy_cnt, n);
    check({name, " done_count"}, done_cnt, 1);
    check({name, " done_at_end"}, done_end, 1);
    check({name, " tx_idle_at_end"}, tx_end, 1);
    check({name, " busy_done_overlap"}, ov, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic samp [$];
    int   starts [2];
    logic [7:0] ch [2];
    int   hs_ok, p, bad, dseen;

    n_checks = 0;
    n_err    = 0;
    start_v  = 4'b0000;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;

    vecs[0] = '{0, 8'h41, 12'b00_1_01000001_0, 10};
    vecs[1] = '{0, 8'h00, 12'b00_1_00000000_0, 10};
    vecs[2] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
    vecs[3] = '{1, 8'h07, 12'b0_1_1_00000111_0, 11};
    vecs[4] = '{1, 8'hA5, 12'b0_1_0_10100101_0, 11};
    vecs[5] = '{2, 8'h07, 12'b0_1_0_00000111_0, 11};
    vecs[6] = '{2, 8'h80, 12'b0_1_0_10000000_0, 11};
    vecs[7] = '{3, 8'hFF, 12'b0_11_11111111_0, 11};
    vecs[8] = '{3, 8'h5A, 12'b0_11_01011010_0, 11};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", int'(tx_v), 15);
    check("reset busy", int'(busy_v), 0);
    check("reset done", int'(done_v), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].inst, vecs[i].data, vecs[i].frame, vecs[i].nbits, 0, 8'h00,
                $sformatf("vec%0d", i));
    end

    // Request for 0x55 in the middle of D2 of a 0x30 frame must be ignored
    run_frame(0, 8'h30, 12'b00_1_00110000_0, 10, 50, 8'h55, "ignored_req");
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    check("ignored_req stays_idle", bad, 0);

    // Back-to-back 0x31/0x32 driven by an upstream wait-high/wait-low handshake
    hs_ok = 0;
    fork
      begin
        for (int k = 0; k < 360; k++) begin
          @(negedge clk);
          samp.push_back(tx_v[0]);
        end
      end
      begin
        int waited;
        logic got_high;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
          data_a[0]  = (b == 0) ? 8'h31 : 8'h32;
          start_v[0] = 1'b1;
          @(negedge clk);
          start_v[0] = 1'b0;
          got_high = busy_v[0];
          waited = 0;
          while (busy_v[0] !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
          end
          if (got_high === 1'b1 && busy_v[0] === 1'b0) hs_ok++;
        end
      end
    join
    p = 0;
    for (int c = 0; c < 2; c++) begin
      while (p < samp.size() && samp[p] !== 1'b0) p++;
      starts[c] = p;
      for (int b = 0; b < 8; b++) begin
        int idx;
        idx = p + CPB/2 + CPB*(b+1);
        ch[c][b] = (idx < samp.size()) ? samp[idx] : 1'bx;
      end
      p = p + CPB*9;
    end
    check("b2b handshake_done", hs_ok, 2);
    check("b2b char0", int'(ch[0]), 8'h31);
    check("b2b char1", int'(ch[1]), 8'h32);
    check("b2b high_gap", starts[1] - (starts[0] + CPB*9), 17);

    // Reset during D3 of a 0x05 frame (D3 = 0), then a clean 0x0A frame
    @(negedge clk);
    data_a[0]  = 8'h05;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (69) @(negedge clk);
    check("midrst tx_before", int'(tx_v[0]), 0);
    check("midrst busy_before", int'(busy_v[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst tx_after", int'(tx_v[0]), 1);
    check("midrst busy_after", int'(busy_v[0]), 0);
    check("midrst done_after", int'(done_v[0]), 0);
    dseen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) dseen++;
    end
    check("midrst no_done_no_activity", dseen, 0);
    run_frame(0, 8'h0A, 12'b00_1_00001010_0, 10, 0, 8'h00, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
